wb_arbiter: RTL

- N-to-1 Wishbone arbiter that shares one peripheral port (memory/interconnect) between several bus controllers, e.g. instruction fetch unit (index 0) and data memory unit (index 1).
- Grants the bus per cycle (cyc-framed) using round-robin priority, and routes the winner's request to the peripheral and the peripheral's response back to the winner.
- Zero added request latency when the bus is idle, so single-cycle fetch controllers that raise stb and expect same-cycle forwarding work unchanged.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_arbiter_if.sv | 25 ++
 rtl/wb_arbiter_rr_pick.sv | 30 +++
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_CTRL       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

endpackage

// File: rtl/wb_arbiter_if.sv
// Classic Wishbone bus bundle; 'controller' drives requests, 'peripheral' answers them.
interface wb_arbiter_if;
    import wb_arb_pkg::*;

    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data_wr;
    logic [WB_DATA_W-1:0] data_rd;
    logic [WB_SEL_W-1:0]  sel;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;
    logic                 err;

    modport controller (
        output addr, data_wr, sel, we, cyc, stb,
        input  data_rd, ack, err
    );

    modport peripheral (
        input  addr, data_wr, sel, we, cyc, stb,
        output data_rd, ack, err
    );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping around.
module rr_pick #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    // NOTE: outputs get a default before any branch so no path leaves them unassigned (no latch).
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i] && (i > int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i] && (i <= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-to-1 cyc-framed round-robin Wishbone arbiter with zero-latency forwarding from idle.
// Define WBARB_TIMEOUT_EN to add a bus watchdog that errors a stalled owner after TIMEOUT_CYCLES.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_CTRL       = DEF_NUM_CTRL,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    wb_arbiter_if.peripheral    ctrl [NUM_CTRL],
    wb_arbiter_if.controller    periph,
    output logic [NUM_CTRL-1:0] o_grant,
    output logic                o_busy
);

    localparam int PTR_W = $clog2(NUM_CTRL);

    arb_state_e           state_q, state_d;
    logic [NUM_CTRL-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic [NUM_CTRL-1:0]  win_gnt;
    logic                 win_valid;
    logic [PTR_W-1:0]     win_idx, owner_idx, sel_idx;
    logic                 p_cyc, p_stb, tmo_hit;
    logic [NUM_CTRL-1:0]  resp_mask, ack_vec, err_vec;

    logic [WB_ADDR_W-1:0] c_addr    [NUM_CTRL];
    logic [WB_DATA_W-1:0] c_data_wr [NUM_CTRL];
    logic [WB_SEL_W-1:0]  c_sel     [NUM_CTRL];
    logic [NUM_CTRL-1:0]  c_we, c_cyc, c_stb;

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        assign c_addr[g]       = ctrl[g].addr;
        assign c_data_wr[g]    = ctrl[g].data_wr;
        assign c_sel[g]        = ctrl[g].sel;
        assign c_we[g]         = ctrl[g].we;
        assign c_cyc[g]        = ctrl[g].cyc;
        assign c_stb[g]        = ctrl[g].stb;
        assign ctrl[g].data_rd = periph.data_rd;
        assign ctrl[g].ack     = ack_vec[g];
        assign ctrl[g].err     = err_vec[g];
    end

    rr_pick #(.N(NUM_CTRL)) u_rr_pick (
        .req_i   (c_cyc),
        .ptr_i   (ptr_q),
        .gnt_o   (win_gnt),
        .valid_o (win_valid)
    );

    always_comb begin
        win_idx   = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (win_gnt[i]) win_idx = PTR_W'(i);
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end

    // NOTE: sequential state updates use non-blocking assignments so all registers sample together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NUM_CTRL - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d = ARB_GRANTED;
                    grant_d = win_gnt;
                    ptr_d   = win_idx;
                end
            end
            ARB_GRANTED: begin
                if (!c_cyc[owner_idx] || tmo_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Release cycle keeps routing the old owner with cyc low; a new winner waits for IDLE.
    always_comb begin
        sel_idx   = (state_q == ARB_GRANTED) ? owner_idx : win_idx;
        p_cyc     = 1'b0;
        p_stb     = 1'b0;
        resp_mask = '0;
        if (state_q == ARB_IDLE) begin
            if (win_valid) begin
                p_cyc     = 1'b1;
                p_stb     = c_stb[win_idx];
                resp_mask = win_gnt;
            end
        end else begin
            p_cyc     = c_cyc[owner_idx] & ~tmo_hit;
            p_stb     = c_stb[owner_idx] & p_cyc;
            resp_mask = p_cyc ? grant_q : '0;
        end
        if (i_rst) begin
            p_cyc = 1'b0;
            p_stb = 1'b0;
        end
        ack_vec = resp_mask & {NUM_CTRL{periph.ack}};
        err_vec = (resp_mask & {NUM_CTRL{periph.err}}) | (tmo_hit ? grant_q : '0);
    end

    assign periph.addr    = c_addr[sel_idx];
    assign periph.data_wr = c_data_wr[sel_idx];
    assign periph.sel     = c_sel[sel_idx];
    assign periph.we      = c_we[sel_idx];
    assign periph.cyc     = p_cyc;
    assign periph.stb     = p_stb;
    assign o_grant        = grant_q;
    assign o_busy         = (state_q == ARB_GRANTED);

`ifdef WBARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != ARB_GRANTED || periph.ack || periph.err) begin
            tmo_cnt_d = '0;
        end else if (p_stb) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end

    assign tmo_hit = (state_q == ARB_GRANTED) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic tmo_unused;
    assign tmo_unused = |TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

endmodule
